updown_cnt_ctrl: RTL and testbench
==================================

// Module: updown_cnt_ctrl
// PURPOSE
//  Sequencer for the WIDTH-bit up/down counter. Drives its en/up_dn_n inputs and reads back cnt.
//  Runs triangle sweeps 0 -> limit -> 0 at a prescaled step rate derived from clk50m.
//  Sits between the control/register layer (start/stop/pause, limit, sweeps) and the counter instance.
// PARAMETERS
//  WIDTH     8          counter width; must match the controlled counter
//  TICK_DIV  5_000_000  clk50m cycles per counter step (10 Hz); legal range >= 2
//  SW_W      8          width of sweep request/progress fields
// PORTS
//  clk50m       in   1        50 MHz system clock
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse: latch limit/sweeps and begin; ignored while busy
//  stop         in   1        abort to IDLE; highest priority after reset
//  pause        in   1        level: freeze stepping and the prescaler while high
//  limit        in   WIDTH    turnaround value (latched at start)
//  sweeps       in   SW_W     number of full sweeps; 0 = run until stop (latched at start)
//  cnt          in   WIDTH    current counter value (feedback)
//  cnt_en       out  1        to counter en: 1-cycle step strobe
//  cnt_up_dn_n  out  1        to counter up_dn_n: 1 = up, 0 = down
//  busy         out  1        state != IDLE
//  done         out  1        1-cycle pulse when the requested sweeps complete
//  sweep_cnt    out  SW_W     completed sweeps in the current run (wraps mod 2^SW_W)
// BEHAVIOUR
//  Reset: state=IDLE, cnt_en=0, cnt_up_dn_n=1, busy=0, done=0, sweep_cnt=0, prescaler=0.
//  FSM states: IDLE, UP, DOWN, DONE.
//  IDLE + start: latch lim_q/sw_q, clear sweep_cnt. Next state is DONE if limit==0, else UP.
//  Prescaler: counts 0..TICK_DIV-1 only in UP/DOWN with pause=0; tick=1 on terminal count, then wraps to 0.
//   Cleared in IDLE, so the first tick falls TICK_DIV cycles after UP is entered.
//  cnt_en is combinational: tick & (UP|DOWN) & !pause & !stop.
//   Counter updates one cycle later; TICK_DIV>=2 guarantees cnt is settled before the next decision.
//  UP on tick:   cnt <  lim_q -> step up.
//                cnt >= lim_q -> go to DOWN, step down in the same tick (no dwell at the peak).
//  DOWN on tick: cnt != 0 -> step down.
//                cnt == 0 -> sweep_cnt+1. If sw_q!=0 and sweep_cnt+1==sw_q: go to DONE, cnt_en=0.
//                Otherwise go to UP and step up in the same tick.
//  cnt_up_dn_n: 0 only when cnt_en=1 and the step is down; 1 otherwise.
//  DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 through DONE.
//  stop (any state): cnt_en forced to 0 in that cycle; next state IDLE. cnt keeps its value; sweep_cnt holds.
//  pause: no steps are issued and the prescaler holds its value; resuming continues the partial tick period.
//  start with cnt != 0: UP runs from the current cnt. cnt > lim_q turns around on the first tick.
//  Simultaneous start+stop in IDLE: stop wins, start is dropped.
//  rst_n low mid-run: immediate return to reset values; the counter resets on the same rst_n.
//  Counter wrap cannot occur: steps are bounded to [0, max(lim_q, cnt_at_start)].
// STRUCTURE
//  Package updown_cnt_ctrl_pkg: typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} ctrl_state_t.
//  Sub-module tick_gen #(DIV): inputs clk50m, rst_n, run, clr; output tick.
//   run = (UP|DOWN) & !pause; clr = IDLE.
//  Top: FSM (always_ff state + always_comb next/outputs), lim_q/sw_q registers, sweep_cnt register.
//  The bench instantiates updown_cnt_ctrl + counter back-to-back.
// TESTING (TICK_DIV=4 unless noted)
//  1 limit=3, sweeps=2, cnt=0, start -> cnt 0,1,2,3,2,1,0,1,2,3,2,1,0; 12 cnt_en pulses, each 4 cycles apart.
//    done one cycle after the final cnt==0 tick; sweep_cnt=2; busy drops the next cycle.
//  2 limit=0, start -> no cnt_en; done pulses 1 cycle after start; sweep_cnt=0.
//  3 limit=5, sweeps=1, pause held 20 cycles at cnt=2 -> no cnt_en and cnt=2 throughout.
//    First step after release follows the remaining prescale count.
//  4 limit=4, sweeps=0, stop at cnt=3 on the down-slope -> cnt_en=0 from the stop cycle; IDLE next cycle.
//    cnt stays 3, done never asserts.
//  5 limit=2, sweeps=0, 300 sweeps -> sweep_cnt wraps 255->0; busy stays 1; no done.
//  6 rst_n low mid-UP at cnt=2 -> all outputs at reset values asynchronously, cnt=0.
//    A start after release behaves as test 1.

Source files
------------

// File: rtl/updown_cnt_ctrl_pkg.sv
// Shared types for the up/down counter sequencer.
// The state encoding and the "stepping" decode are used by the controller top.
package updown_cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    // True in the states where the prescaler runs and steps may be issued.
    function automatic logic is_stepping(input ctrl_state_t s);
        logic r;
        case (s)
            UP:      r = 1'b1;
            DOWN:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/updown_cnt_ctrl_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 while run is high and pulses tick on the
// terminal count. The count holds while run is low, so a pause resumes mid-period.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_r;

    // Prescale counter: clear wins over run, wraps on the terminal count.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            div_cnt_r <= {CW{1'b0}};
        end else if (run) begin
            if (div_cnt_r == TERM) begin
                div_cnt_r <= {CW{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + CW'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    assign tick = run & (div_cnt_r == TERM);

endmodule

// File: rtl/updown_cnt_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: drives en/up_dn_n,
// watches cnt, and counts completed 0 -> limit -> 0 sweeps.
module updown_cnt_ctrl
    import updown_cnt_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 5_000_000,
    parameter int SW_W     = 8
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] limit,
    input  logic [SW_W-1:0]  sweeps,
    input  logic [WIDTH-1:0] cnt,
    output logic             cnt_en,
    output logic             cnt_up_dn_n,
    output logic             busy,
    output logic             done,
    output logic [SW_W-1:0]  sweep_cnt
);

    ctrl_state_t      state_r;
    ctrl_state_t      state_s;
    logic [WIDTH-1:0] lim_r;
    logic [SW_W-1:0]  sw_r;
    logic [SW_W-1:0]  sweep_cnt_r;
    logic [SW_W-1:0]  sweep_nxt_s;
    logic             tick_s;
    logic             run_s;
    logic             clr_s;
    logic             cnt_en_s;
    logic             up_dn_n_s;
    logic             start_acc_s;
    logic             sweep_inc_s;

    assign run_s = is_stepping(state_r) & ~pause;
    assign clr_s = (state_r == IDLE);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .run    (run_s),
        .clr    (clr_s),
        .tick   (tick_s)
    );

    // Next-state and step decisions; turnarounds step in the same tick.
    always_comb begin
        state_s     = state_r;
        cnt_en_s    = 1'b0;
        up_dn_n_s   = 1'b1;
        start_acc_s = 1'b0;
        sweep_inc_s = 1'b0;
        sweep_nxt_s = sweep_cnt_r + SW_W'(1);
        case (state_r)
            IDLE: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (start) begin
                    start_acc_s = 1'b1;
                    state_s     = (limit == {WIDTH{1'b0}}) ? DONE : UP;
                end else begin
                    state_s = IDLE;
                end
            end
            UP: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (tick_s) begin
                    cnt_en_s = 1'b1;
                    if (cnt < lim_r) begin
                        up_dn_n_s = 1'b1;
                    end else begin
                        up_dn_n_s = 1'b0;
                        state_s   = DOWN;
                    end
                end else begin
                    state_s = UP;
                end
            end
            DOWN: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (tick_s) begin
                    if (cnt != {WIDTH{1'b0}}) begin
                        cnt_en_s  = 1'b1;
                        up_dn_n_s = 1'b0;
                    end else begin
                        sweep_inc_s = 1'b1;
                        if ((sw_r != {SW_W{1'b0}}) && (sweep_nxt_s == sw_r)) begin
                            state_s = DONE;
                        end else begin
                            cnt_en_s  = 1'b1;
                            up_dn_n_s = 1'b1;
                            state_s   = UP;
                        end
                    end
                end else begin
                    state_s = DOWN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run parameters captured on an accepted start.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            lim_r <= {WIDTH{1'b0}};
            sw_r  <= {SW_W{1'b0}};
        end else if (start_acc_s) begin
            lim_r <= limit;
            sw_r  <= sweeps;
        end else begin
            lim_r <= lim_r;
            sw_r  <= sw_r;
        end
    end

    // Completed-sweep counter; wraps freely and holds across a stop.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt_r <= {SW_W{1'b0}};
        end else if (start_acc_s) begin
            sweep_cnt_r <= {SW_W{1'b0}};
        end else if (sweep_inc_s) begin
            sweep_cnt_r <= sweep_nxt_s;
        end else begin
            sweep_cnt_r <= sweep_cnt_r;
        end
    end

    assign cnt_en      = cnt_en_s;
    assign cnt_up_dn_n = up_dn_n_s;
    assign busy        = (state_r != IDLE);
    assign done        = (state_r == DONE);
    assign sweep_cnt   = sweep_cnt_r;

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// Bench for updown_cnt_ctrl with a behavioural up/down counter closing the loop.
// Table-driven sweep runs plus hand sequences for pause, stop, wrap and reset.
module tb_updown_cnt_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
    localparam int SW_W  = 8;

    logic             clk50m = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] limit;
    logic [SW_W-1:0]  sweeps;
    logic [WIDTH-1:0] cnt;
    logic             cnt_en;
    logic             cnt_up_dn_n;
    logic             busy;
    logic             done;
    logic [SW_W-1:0]  sweep_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int limit;
        int sweeps;
        int exp_pulses;
        int exp_sweep;
        int exp_done_c;
    } vec_t;

    vec_t tbl[5];

    always #10 clk50m = ~clk50m;

    updown_cnt_ctrl #(
        .WIDTH    (WIDTH),
        .TICK_DIV (DIV),
        .SW_W     (SW_W)
    ) dut (
        .clk50m      (clk50m),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .limit       (limit),
        .sweeps      (sweeps),
        .cnt         (cnt),
        .cnt_en      (cnt_en),
        .cnt_up_dn_n (cnt_up_dn_n),
        .busy        (busy),
        .done        (done),
        .sweep_cnt   (sweep_cnt)
    );

    // Controlled counter, reset by the same rst_n.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) cnt <= 8'd0;
        else if (cnt_en) cnt <= cnt_up_dn_n ? cnt + 8'd1 : cnt - 8'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counter value after k steps of a triangle 0 -> L -> 0 starting at 0.
    function automatic int tri_val(input int l, input int k);
        int m;
        m = k % (2 * l);
        return (m <= l) ? m : 2 * l - m;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, " cnt_en"}, int'(cnt_en), 0);
        chk({tag, " up_dn_n"}, int'(cnt_up_dn_n), 1);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " sweep_cnt"}, int'(sweep_cnt), 0);
        chk({tag, " cnt"}, int'(cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk50m);
        rst_n = 1'b0;
        #1;
        @(negedge clk50m);
        rst_n = 1'b1;
    endtask

    task automatic run_scenario(input vec_t v, input string tag);
        int pulses = 0, dones = 0, done_c = 0, idle_c = 0, pend = 0;
        int sp_err = 0, tr_err = 0, dir_err = 0;
        @(negedge clk50m);
        limit  = 8'(v.limit);
        sweeps = 8'(v.sweeps);
        start  = 1'b1;
        for (int c = 1; c <= 2000 && idle_c == 0; c++) begin
            @(negedge clk50m);
            start = 1'b0;
            #1;
            if (pend > 0) begin
                if (int'(cnt) != tri_val(v.limit, pend)) tr_err++;
                pend = 0;
            end
            if (cnt_en) begin
                pulses++;
                if (c != DIV * pulses) sp_err++;
                if (int'(cnt_up_dn_n) != (((pulses - 1) % (2 * v.limit)) < v.limit ? 1 : 0)) dir_err++;
                pend = pulses;
            end
            if (done) begin
                dones++;
                done_c = c;
            end
            if (!busy) idle_c = c;
        end
        chk({tag, " finished"}, int'(idle_c != 0), 1);
        chk({tag, " pulses"}, pulses, v.exp_pulses);
        chk({tag, " spacing"}, sp_err, 0);
        chk({tag, " trajectory"}, tr_err, 0);
        chk({tag, " direction"}, dir_err, 0);
        chk({tag, " done_count"}, dones, 1);
        chk({tag, " done_cycle"}, done_c, v.exp_done_c);
        chk({tag, " busy_drop"}, idle_c, v.exp_done_c + 1);
        chk({tag, " sweep_cnt"}, int'(sweep_cnt), v.exp_sweep);
        chk({tag, " final_cnt"}, int'(cnt), 0);
    endtask

    initial begin
        int first_post, en_err, cnt_err, dn, busy_low, wrap_seen;
        int cnt33;
        logic [SW_W-1:0] prev_sw;

        tbl[0] = '{3, 2, 12, 2, 53};
        tbl[1] = '{0, 5, 0, 0, 1};
        tbl[2] = '{1, 3, 6, 3, 29};
        tbl[3] = '{5, 1, 10, 1, 45};
        tbl[4] = '{2, 1, 4, 1, 21};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        limit = 8'd0; sweeps = 8'd0;
        #1;
        reset_checks("reset");
        @(negedge clk50m);
        @(negedge clk50m);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_scenario(tbl[i], $sformatf("vec%0d", i));
        end

        // Pause for 20 cycles mid-period at cnt=2.
        @(negedge clk50m);
        limit = 8'd5; sweeps = 8'd1; start = 1'b1;
        first_post = 0; en_err = 0; cnt_err = 0; cnt33 = -1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk50m);
            start = 1'b0;
            if (c == 10) pause = 1'b1;
            if (c == 30) pause = 1'b0;
            #1;
            if (c >= 10 && c <= 29) begin
                if (cnt_en) en_err++;
                if (cnt != 8'd2) cnt_err++;
            end
            if (c >= 10 && cnt_en && first_post == 0) first_post = c;
            if (c == 33) cnt33 = int'(cnt);
        end
        chk("pause no_steps", en_err, 0);
        chk("pause cnt_hold", cnt_err, 0);
        chk("pause resume_cycle", first_post, 32);
        chk("pause resume_cnt", cnt33, 3);
        @(negedge clk50m);
        stop = 1'b1;
        #1;
        chk("pause stop cnt_en", int'(cnt_en), 0);
        @(negedge clk50m);
        stop = 1'b0;
        #1;
        chk("pause stop busy", int'(busy), 0);
        do_reset();

        // Stop on a down-slope tick at cnt=3.
        @(negedge clk50m);
        limit = 8'd4; sweeps = 8'd0; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk50m);
            start = 1'b0;
            if (c == 24) stop = 1'b1;
            if (c == 25) stop = 1'b0;
            #1;
            if (c == 20) begin
                chk("stop turn cnt_en", int'(cnt_en), 1);
                chk("stop turn dir", int'(cnt_up_dn_n), 0);
            end
            if (c == 24) begin
                chk("stop cnt_en", int'(cnt_en), 0);
                chk("stop cnt", int'(cnt), 3);
            end
            if (c == 25) chk("stop idle", int'(busy), 0);
        end
        en_err = 0; cnt_err = 0; dn = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk50m);
            #1;
            if (cnt_en) en_err++;
            if (cnt != 8'd3) cnt_err++;
            if (done) dn++;
        end
        chk("stop after en", en_err, 0);
        chk("stop after cnt", cnt_err, 0);
        chk("stop no done", dn, 0);
        do_reset();

        // 300 continuous sweeps: sweep_cnt wraps, busy holds, no done.
        @(negedge clk50m);
        limit = 8'd2; sweeps = 8'd0; start = 1'b1;
        busy_low = 0; dn = 0; wrap_seen = 0; prev_sw = 8'd0;
        for (int c = 1; c <= 4810; c++) begin
            @(negedge clk50m);
            start = 1'b0;
            #1;
            if (!busy) busy_low++;
            if (done) dn++;
            if (prev_sw == 8'd255 && sweep_cnt == 8'd0) wrap_seen = 1;
            prev_sw = sweep_cnt;
        end
        chk("wrap sweep_cnt", int'(sweep_cnt), 44);
        chk("wrap seen", wrap_seen, 1);
        chk("wrap busy", busy_low, 0);
        chk("wrap no done", dn, 0);
        @(negedge clk50m);
        stop = 1'b1;
        @(negedge clk50m);
        stop = 1'b0;
        do_reset();

        // Reset mid-UP at cnt=2, then a normal run.
        @(negedge clk50m);
        limit = 8'd3; sweeps = 8'd2; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk50m);
            start = 1'b0;
            if (c == 10) begin
                chk("pre_reset cnt", int'(cnt), 2);
                rst_n = 1'b0;
            end
            #1;
        end
        reset_checks("midrun reset");
        @(negedge clk50m);
        rst_n = 1'b1;
        run_scenario(tbl[0], "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
